// File: rtl/motor_ctrl_pkg.sv
// Shared types, widths and input-check helpers for the motor run timer.
package motor_ctrl_pkg;

  localparam int MOTOR_W = 6;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPINUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic bcd_valid(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

  function automatic logic is_onehot(input logic [MOTOR_W-1:0] m);
    return (m != '0) && ((m & (m - MOTOR_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bcd3_down_counter.sv
// Three-digit BCD down-counter with clear, parallel load and borrowing decrement.
module bcd3_down_counter
  import motor_ctrl_pkg::*;
(
  input  logic               clk_sys,
  input  logic               rst_b,
  input  logic               clear,
  input  logic               load,
  input  logic               dec,
  input  logic [DIGIT_W-1:0] d0,
  input  logic [DIGIT_W-1:0] d1,
  input  logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] q0,
  output logic [DIGIT_W-1:0] q1,
  output logic [DIGIT_W-1:0] q2,
  output logic               zero
);

  logic borrow0;
  logic borrow1;

  assign zero    = (q0 == '0) && (q1 == '0) && (q2 == '0);
  assign borrow0 = (q0 == '0);
  assign borrow1 = borrow0 && (q1 == '0);

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (clear) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (load) begin
      q0 <= d0;
      q1 <= d1;
      q2 <= d2;
    end else if (dec && !zero) begin
      // a digit at zero wraps to nine and lends the borrow upward
      q0 <= borrow0 ? DIGIT_W'(9) : q0 - DIGIT_W'(1);
      if (borrow0) q1 <= (q1 == '0) ? DIGIT_W'(9) : q1 - DIGIT_W'(1);
      if (borrow1) q2 <= q2 - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/motor_timer_ctrl.sv
// Motor run timer: validates a start request, drives one motor for a BCD time, supports pause/abort.
// Optional MOTOR_DEADTIME_EN inserts a SPINUP dead-time before every entry to RUN.
//
// state  | meaning
// IDLE   | waiting for start, motor off
// SPINUP | dead-time before drive, motor off, timer frozen
// RUN    | motor driven, prescaler and remaining time counting
// PAUSE  | motor off, prescaler and remaining time held
// DONE   | one-cycle completion, done pulsed
module motor_timer_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MOTOR_W-1:0] Motor,
  input  logic [DIGIT_W-1:0] TValue0,
  input  logic [DIGIT_W-1:0] TValue1,
  input  logic [DIGIT_W-1:0] TValue2,
  output logic [MOTOR_W-1:0] MotorDrv,
  output logic [DIGIT_W-1:0] Remain0,
  output logic [DIGIT_W-1:0] Remain1,
  output logic [DIGIT_W-1:0] Remain2,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEAD_CYCLES < 1) begin : g_bad_param
    $error("motor_timer_ctrl: TICK_DIV must be >= 2 and DEAD_CYCLES >= 1");
  end

`ifdef MOTOR_DEADTIME_EN
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam state_t RUN_ENTRY = ST_SPINUP;
  logic [DW-1:0] dead_cnt;
`else
  localparam state_t RUN_ENTRY = ST_RUN;
`endif

  state_t             state, state_nxt;
  logic [PW-1:0]      presc, presc_nxt;
  logic [MOTOR_W-1:0] sel, sel_nxt;
  logic               err_nxt;
  logic               cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic               start_ok, tick, rem_one;

  assign start_ok = is_onehot(Motor) && bcd_valid(TValue0) && bcd_valid(TValue1)
                    && bcd_valid(TValue2) && ({TValue2, TValue1, TValue0} != '0);
  assign tick     = (state == ST_RUN) && (presc == PRESC_LAST);
  assign rem_one  = ({Remain2, Remain1, Remain0} == (3 * DIGIT_W)'(1));

  bcd3_down_counter u_remain (
    .clk_sys (sysclk),
    .rst_b   (rst),
    .clear   (cnt_clear),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .d0      (TValue0),
    .d1      (TValue1),
    .d2      (TValue2),
    .q0      (Remain0),
    .q1      (Remain1),
    .q2      (Remain2),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    sel_nxt   = sel;
    err_nxt   = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (state != ST_IDLE && abort) begin
      state_nxt = ST_IDLE;
      presc_nxt = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (start_ok) begin
              state_nxt = RUN_ENTRY;
              presc_nxt = '0;
              sel_nxt   = Motor;
              cnt_load  = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
`ifdef MOTOR_DEADTIME_EN
        ST_SPINUP: begin
          if (dead_cnt == '0) state_nxt = ST_RUN;
        end
`endif
        ST_RUN: begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          cnt_dec   = tick;
          // a run with nothing left can only be a corrupted count; finish it
          if ((tick && rem_one) || cnt_zero) state_nxt = ST_DONE;
          else if (start)                    state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start) state_nxt = RUN_ENTRY;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      presc    <= '0;
      sel      <= '0;
      MotorDrv <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      sel      <= sel_nxt;
      MotorDrv <= (state_nxt == ST_RUN) ? sel_nxt : '0;
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_DONE);
      err      <= err_nxt;
    end
  end

`ifdef MOTOR_DEADTIME_EN
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst)                                            dead_cnt <= '0;
    else if (state_nxt == ST_SPINUP && state != ST_SPINUP) dead_cnt <= DEAD_LOAD;
    else if (state == ST_SPINUP && dead_cnt != '0)       dead_cnt <= dead_cnt - DW'(1);
  end
`endif

endmodule

// File: tb/tb_motor_timer_ctrl.sv
// Scoreboard bench for motor_timer_ctrl with TICK_DIV=4, DEAD_CYCLES=3.
module tb_motor_timer_ctrl;

  typedef struct {
    int          cyc;
    string       name;
    logic [5:0]  drv;
    logic [11:0] rem;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

`ifdef MOTOR_DEADTIME_EN
  localparam int SP = 3;
`else
  localparam int SP = 0;
`endif

  logic       sysclk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] Motor;
  logic [3:0] TValue0, TValue1, TValue2;
  logic [5:0] MotorDrv;
  logic [3:0] Remain0, Remain1, Remain2;
  logic       busy, done, err;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  logic [5:0]  inv_m [4] = '{6'b011000, 6'b000000, 6'b000100, 6'b000100};
  logic [11:0] inv_t [4] = '{12'h005, 12'h005, 12'h0A1, 12'h000};

  motor_timer_ctrl #(.TICK_DIV(4), .DEAD_CYCLES(3)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .Motor    (Motor),
    .TValue0  (TValue0),
    .TValue1  (TValue1),
    .TValue2  (TValue2),
    .MotorDrv (MotorDrv),
    .Remain0  (Remain0),
    .Remain1  (Remain1),
    .Remain2  (Remain2),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // monitor: pops every expectation due this cycle and compares it against the outputs
  always @(negedge sysclk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (MotorDrv !== e.drv || {Remain2, Remain1, Remain0} !== e.rem ||
                   busy !== e.busy || done !== e.done || err !== e.err) begin
        failures++;
        $display("FAIL %s @%0d: got drv=%b rem=%h busy=%b done=%b err=%b, want drv=%b rem=%h busy=%b done=%b err=%b",
                 e.name, cyc, MotorDrv, {Remain2, Remain1, Remain0}, busy, done, err,
                 e.drv, e.rem, e.busy, e.done, e.err);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [5:0] d,
                           input logic [11:0] r, input logic b, input logic dn, input logic er);
    exp_t e;
    e.cyc = c; e.name = nm; e.drv = d; e.rem = r; e.busy = b; e.done = dn; e.err = er;
    sbq.push_back(e);
  endtask

  task automatic set_in(input logic [5:0] m, input logic [11:0] t);
    Motor = m;
    {TValue2, TValue1, TValue0} = t;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int e0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    set_in(6'b000000, 12'h000);
    step(2);
    expect_at(cyc, "reset", 6'b0, 12'h000, 0, 0, 0);
    rst = 1'b1;
    step(2);

    // basic run of 002, inputs changed mid-run must not matter
    set_in(6'b010000, 12'h002);
    do_start();
    e0 = cyc;
    expect_at(e0 + SP,     "run_drv",    6'b010000, 12'h002, 1, 0, 0);
    expect_at(e0 + SP + 3, "run_pre",    6'b010000, 12'h002, 1, 0, 0);
    expect_at(e0 + SP + 4, "tick1",      6'b010000, 12'h001, 1, 0, 0);
    expect_at(e0 + SP + 7, "tick1_hold", 6'b010000, 12'h001, 1, 0, 0);
    expect_at(e0 + SP + 8, "done",       6'b000000, 12'h000, 1, 1, 0);
    expect_at(e0 + SP + 9, "done_idle",  6'b000000, 12'h000, 0, 0, 0);
    expect_at(e0 + SP + 10,"idle_stay",  6'b000000, 12'h000, 0, 0, 0);
    step(2);
    set_in(6'b000001, 12'h999);
    step(SP + 8);

    // borrow across digits, then abort
    set_in(6'b000001, 12'h100);
    do_start();
    e0 = cyc;
    expect_at(e0 + SP + 3, "borrow_pre", 6'b000001, 12'h100, 1, 0, 0);
    expect_at(e0 + SP + 4, "borrow",     6'b000001, 12'h099, 1, 0, 0);
    step(SP + 5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    expect_at(cyc,     "abort",      6'b0, 12'h000, 0, 0, 0);
    expect_at(cyc + 2, "abort_idle", 6'b0, 12'h000, 0, 0, 0);
    step(3);

    // rejected starts
    for (int i = 0; i < 4; i++) begin
      set_in(inv_m[i], inv_t[i]);
      do_start();
      expect_at(cyc,     $sformatf("err_%0d", i),     6'b0, 12'h000, 0, 0, 1);
      expect_at(cyc + 1, $sformatf("err_end_%0d", i), 6'b0, 12'h000, 0, 0, 0);
      step(2);
    end

    // pause and resume keep the prescaler phase
    set_in(6'b000010, 12'h003);
    do_start();
    e0 = cyc;
    expect_at(e0 + SP, "p_run", 6'b000010, 12'h003, 1, 0, 0);
    step(SP + 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    e0 = cyc;
    expect_at(e0,      "pause",       6'b0, 12'h003, 1, 0, 0);
    expect_at(e0 + 10, "pause_hold",  6'b0, 12'h003, 1, 0, 0);
    expect_at(e0 + 20, "pause_hold2", 6'b0, 12'h003, 1, 0, 0);
    step(20);
    do_start();
    e0 = cyc;
    expect_at(e0 + SP,     "resume",      6'b000010, 12'h003, 1, 0, 0);
    expect_at(e0 + SP + 1, "resume_pre",  6'b000010, 12'h003, 1, 0, 0);
    expect_at(e0 + SP + 2, "resume_tick", 6'b000010, 12'h002, 1, 0, 0);
    step(SP + 3);
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    expect_at(cyc,     "start_abort", 6'b0, 12'h000, 0, 0, 0);
    expect_at(cyc + 3, "no_done",     6'b0, 12'h000, 0, 0, 0);
    step(4);

    // asynchronous reset mid-run
    set_in(6'b100000, 12'h005);
    do_start();
    step(SP + 2);
    expect_at(cyc, "pre_reset", 6'b100000, 12'h005, 1, 0, 0);
    step(1);
    rst = 1'b0;
    expect_at(cyc, "async_rst", 6'b0, 12'h000, 0, 0, 0);
    step(2);
    expect_at(cyc, "rst_hold", 6'b0, 12'h000, 0, 0, 0);
    rst = 1'b1;
    expect_at(cyc, "rst_release", 6'b0, 12'h000, 0, 0, 0);
    step(1);
    expect_at(cyc, "post_rst_idle", 6'b0, 12'h000, 0, 0, 0);
    step(2);

    // run entry with and without dead-time
    set_in(6'b100000, 12'h001);
    do_start();
    e0 = cyc;
`ifdef MOTOR_DEADTIME_EN
    expect_at(e0,     "dt_spin0",   6'b000000, 12'h001, 1, 0, 0);
    expect_at(e0 + 2, "dt_spin2",   6'b000000, 12'h001, 1, 0, 0);
    expect_at(e0 + 3, "dt_run",     6'b100000, 12'h001, 1, 0, 0);
    expect_at(e0 + 6, "dt_run_end", 6'b100000, 12'h001, 1, 0, 0);
    expect_at(e0 + 7, "dt_done",    6'b000000, 12'h000, 1, 1, 0);
    expect_at(e0 + 8, "dt_idle",    6'b000000, 12'h000, 0, 0, 0);
    step(9);
`else
    expect_at(e0,     "nodt_drv",  6'b100000, 12'h001, 1, 0, 0);
    expect_at(e0 + 3, "nodt_hold", 6'b100000, 12'h001, 1, 0, 0);
    expect_at(e0 + 4, "nodt_done", 6'b000000, 12'h000, 1, 1, 0);
    expect_at(e0 + 5, "nodt_idle", 6'b000000, 12'h000, 0, 0, 0);
    step(6);
`endif

    step(2);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never compared (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
